weight_mem_sequencer: RTL and testbench
=======================================

Name: weight_mem_sequencer

Overview:
Controller for the 4-D weight memory (index order [in][out][k_y][k_x], DATA_SIZE-bit words). It accepts a valid/ready stream of weights and turns it into ordered single-word writes. It then replays the stored kernel as an ordered read sweep, with a valid/ready handshake to the convolution datapath. It sits between the host/DMA weight stream and the weight memory, and owns every memory write and read index.

Parameters:
NUM_INPUTS, 1, input-channel count (index_in range)
NUM_OUTPUTS, 1, output-channel count (index_out range)
DIM, 1, kernel side; k_y and k_x range 0..DIM-1
DATA_SIZE, 64, weight word width (IEEE double bits)
IDX_W, 16, width of every index port

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
load_start  in  1  one-cycle pulse: begin loading NUM_INPUTS*NUM_OUTPUTS*DIM*DIM words
rd_start  in  1  one-cycle pulse: begin a read sweep
clear  in  1  synchronous abort to IDLE
in_valid  in  1  weight stream valid
in_ready  out  1  weight stream ready
in_data  in  DATA_SIZE  weight stream word
mem_write  out  1  memory write strobe
mem_index_in, mem_index_out, mem_index_k_y, mem_index_k_x  out  IDX_W each  write address
mem_wdata  out  DATA_SIZE  write data
mem_rd_index_in, mem_rd_index_out, mem_rd_index_y, mem_rd_index_x  out  IDX_W each  read address
rd_valid  out  1  read address/word valid (memory read is combinational, so the word is valid in the same cycle)
rd_ready  in  1  consumer accepts the current word
rd_last  out  1  high with rd_valid on the final word of a sweep
load_done  out  1  one-cycle pulse after the final write
rd_done  out  1  one-cycle pulse after the final read handshake
loaded  out  1  memory holds a complete kernel set
busy  out  1  state is LOAD or READ

Behaviour:
- Reset (async, rst_n=0): state IDLE; all counters 0; all outputs 0, including loaded, in_ready, mem_write, rd_valid, the pulses and all indices. Memory contents are not touched.
- States: IDLE, LOAD, LOADED, READ. busy = (LOAD | READ).
- IDLE: load_start -> LOAD. rd_start is ignored.
- LOAD:
  - in_ready=1. A beat is accepted when in_valid & in_ready.
  - Each accepted beat produces, on the next cycle, mem_write=1 with the current counter values on the write index ports and the beat's word on mem_wdata. Write latency is 1 cycle; mem_write is low otherwise.
  - Counter order: k_x fastest, then k_y, then out, then in. Each counter wraps to 0 at its limit and carries into the next.
  - On the last beat (all counters at max): in_ready drops in the following cycle; load_done pulses in the same cycle as the final mem_write; loaded=1; counters return to 0; state -> LOADED.
  - loaded=0 for the whole of LOAD.
- LOADED: load_start -> LOAD (loaded cleared). rd_start -> READ. If both pulse in the same cycle, load_start wins.
- READ:
  - rd_valid=1 and the read indices hold the current counter values.
  - Counters advance, in the same order as LOAD, only when rd_valid & rd_ready. The indices are stable while rd_ready=0.
  - rd_last=1 on the final address.
  - The final handshake gives: rd_done pulse next cycle, rd_valid=0, state -> LOADED.
  - A sweep can be repeated any number of times without reloading.
- load_start or rd_start while busy: ignored.
- clear (synchronous, highest priority after reset): state -> IDLE; counters 0; loaded=0; in_ready, rd_valid and mem_write drop on the next edge. A pending registered write from the previous cycle still completes.
- rst_n asserted mid-LOAD or mid-READ: immediate return to the reset values. A partial load is never reported as loaded.
- in_valid outside LOAD: ignored, and no write occurs.
- Counter limits are parameters minus 1. All counters are IDX_W wide, zero-extended. With DIM=1, k_y and k_x stay at 0.

Decomposition:
- Shared package weight_pkg holds:
  - the state enum (IDLE/LOAD/LOADED/READ);
  - IDX_W;
  - a total-word-count function NUM_INPUTS*NUM_OUTPUTS*DIM*DIM.
- One natural sub-module: weight_idx_counter. It is a 4-level nested wrapping counter with enable, sync clear, current indices and a last flag. It is instantiated twice, once for write addresses and once for read addresses.

Test Plan:
1. NI=1, NO=1, DIM=3; load_start, then 9 back-to-back beats with data 1.0..9.0 -> 9 mem_write cycles with (k_y,k_x) = (0,0),(0,1),(0,2),(1,0)…(2,2); word 3.0 at [0][0][0][2]; load_done pulses once, with loaded=1 on the following cycle.
2. Same setup, in_valid toggled 1,0,1,0 -> a write only one cycle after each accepted beat; indices advance only on acceptance; 9 writes total.
3. NI=2, NO=2, DIM=2; rd_start, rd_ready held 1 -> 16 consecutive rd_valid cycles in order [0][0][0][0]…[1][1][1][1]; rd_last on the 16th; rd_done the next cycle; a second rd_start repeats the sequence.
4. During READ, rd_ready=0 for 3 cycles at word 5 -> read indices hold [0][1][0][1] for those cycles; the sweep still completes with 16 handshakes.
5. load_start and rd_start pulsed together in LOADED -> enters LOAD, loaded=0, rd_valid stays 0.
6. rst_n low after 4 of 9 load beats -> all outputs 0 immediately, loaded=0; a following rd_start is ignored until a full reload completes.

Source files
------------

// File: rtl/weight_pkg.sv
// Shared definitions for the weight memory sequencer: controller states,
// default index width and the kernel word-count helper.
package weight_pkg;

   localparam int IDX_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      LOADED = 2'd2,
      READ   = 2'd3
   } state_t;

   function automatic int total_words(input int ni, input int no, input int dim);
      return ni * no * dim * dim;
   endfunction

endpackage

// File: rtl/weight_idx_counter.sv
// Four-level nested wrapping index counter, [in][out][k_y][k_x] with k_x fastest.
// Advances on en, returns to zero on clr, and flags the final index tuple.
module weight_idx_counter #(
   parameter int NUM_INPUTS  = 1,
   parameter int NUM_OUTPUTS = 1,
   parameter int DIM         = 1,
   parameter int IDX_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   output logic [IDX_W-1:0] idx_in,
   output logic [IDX_W-1:0] idx_out,
   output logic [IDX_W-1:0] idx_y,
   output logic [IDX_W-1:0] idx_x,
   output logic             last
);

   localparam logic [IDX_W-1:0] MAX_IN  = IDX_W'(NUM_INPUTS - 1);
   localparam logic [IDX_W-1:0] MAX_OUT = IDX_W'(NUM_OUTPUTS - 1);
   localparam logic [IDX_W-1:0] MAX_D   = IDX_W'(DIM - 1);

   logic wrap_x;
   logic wrap_y;
   logic wrap_out;

   // Each wrap term already includes the carry from every faster level.
   assign wrap_x   = (idx_x == MAX_D);
   assign wrap_y   = wrap_x & (idx_y == MAX_D);
   assign wrap_out = wrap_y & (idx_out == MAX_OUT);
   assign last     = wrap_out & (idx_in == MAX_IN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_in  <= '0;
         idx_out <= '0;
         idx_y   <= '0;
         idx_x   <= '0;
      end else if (clr) begin
         idx_in  <= '0;
         idx_out <= '0;
         idx_y   <= '0;
         idx_x   <= '0;
      end else if (en) begin
         idx_x <= wrap_x ? '0 : idx_x + IDX_W'(1);
         if (wrap_x)
            idx_y <= (idx_y == MAX_D) ? '0 : idx_y + IDX_W'(1);
         if (wrap_y)
            idx_out <= (idx_out == MAX_OUT) ? '0 : idx_out + IDX_W'(1);
         if (wrap_out)
            idx_in <= (idx_in == MAX_IN) ? '0 : idx_in + IDX_W'(1);
      end
   end

endmodule

// File: rtl/weight_mem_sequencer.sv
// Weight memory controller: turns a valid/ready weight stream into ordered
// single-word writes, then replays the kernel as a handshaked read sweep.
module weight_mem_sequencer #(
   parameter int NUM_INPUTS  = 1,
   parameter int NUM_OUTPUTS = 1,
   parameter int DIM         = 1,
   parameter int DATA_SIZE   = 64,
   parameter int IDX_W       = weight_pkg::IDX_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_start,
   input  logic                 rd_start,
   input  logic                 clear,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_SIZE-1:0] in_data,
   output logic                 mem_write,
   output logic [IDX_W-1:0]     mem_index_in,
   output logic [IDX_W-1:0]     mem_index_out,
   output logic [IDX_W-1:0]     mem_index_k_y,
   output logic [IDX_W-1:0]     mem_index_k_x,
   output logic [DATA_SIZE-1:0] mem_wdata,
   output logic [IDX_W-1:0]     mem_rd_index_in,
   output logic [IDX_W-1:0]     mem_rd_index_out,
   output logic [IDX_W-1:0]     mem_rd_index_y,
   output logic [IDX_W-1:0]     mem_rd_index_x,
   output logic                 rd_valid,
   input  logic                 rd_ready,
   output logic                 rd_last,
   output logic                 load_done,
   output logic                 rd_done,
   output logic                 loaded,
   output logic                 busy
);
   import weight_pkg::*;

   state_t           state;
   logic             accept;
   logic             rd_hs;
   logic             wr_last;
   logic             rd_cnt_last;
   logic [IDX_W-1:0] wr_in, wr_out, wr_y, wr_x;

   // in_ready is only ever high in LOAD, so accept needs no state term.
   assign accept  = in_valid & in_ready;
   assign rd_hs   = rd_valid & rd_ready;
   assign rd_last = rd_valid & rd_cnt_last;
   assign busy    = (state == LOAD) | (state == READ);

   weight_idx_counter #(
      .NUM_INPUTS (NUM_INPUTS),
      .NUM_OUTPUTS(NUM_OUTPUTS),
      .DIM        (DIM),
      .IDX_W      (IDX_W)
   ) u_wr_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (accept),
      .clr    (clear),
      .idx_in (wr_in),
      .idx_out(wr_out),
      .idx_y  (wr_y),
      .idx_x  (wr_x),
      .last   (wr_last)
   );

   weight_idx_counter #(
      .NUM_INPUTS (NUM_INPUTS),
      .NUM_OUTPUTS(NUM_OUTPUTS),
      .DIM        (DIM),
      .IDX_W      (IDX_W)
   ) u_rd_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (rd_hs),
      .clr    (clear),
      .idx_in (mem_rd_index_in),
      .idx_out(mem_rd_index_out),
      .idx_y  (mem_rd_index_y),
      .idx_x  (mem_rd_index_x),
      .last   (rd_cnt_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         in_ready      <= 1'b0;
         rd_valid      <= 1'b0;
         mem_write     <= 1'b0;
         mem_index_in  <= '0;
         mem_index_out <= '0;
         mem_index_k_y <= '0;
         mem_index_k_x <= '0;
         mem_wdata     <= '0;
         load_done     <= 1'b0;
         rd_done       <= 1'b0;
         loaded        <= 1'b0;
      end else begin
         mem_write <= accept & ~clear;
         load_done <= 1'b0;
         rd_done   <= 1'b0;
         if (accept && !clear) begin
            mem_index_in  <= wr_in;
            mem_index_out <= wr_out;
            mem_index_k_y <= wr_y;
            mem_index_k_x <= wr_x;
            mem_wdata     <= in_data;
         end
         if (clear) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            rd_valid <= 1'b0;
            loaded   <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (load_start) begin
                     state    <= LOAD;
                     in_ready <= 1'b1;
                  end
               end
               LOAD: begin
                  if (accept && wr_last) begin
                     state     <= LOADED;
                     in_ready  <= 1'b0;
                     load_done <= 1'b1;
                     loaded    <= 1'b1;
                  end
               end
               LOADED: begin
                  if (load_start) begin
                     state    <= LOAD;
                     in_ready <= 1'b1;
                     loaded   <= 1'b0;
                  end else if (rd_start) begin
                     state    <= READ;
                     rd_valid <= 1'b1;
                  end
               end
               READ: begin
                  if (rd_hs && rd_cnt_last) begin
                     state    <= LOADED;
                     rd_valid <= 1'b0;
                     rd_done  <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_weight_mem_sequencer.sv
// Directed bench: a 1x1x3x3 instance (A) for loading/reset and a 2x2x2x2
// instance (B) for read sweeps, priority and clear.
`timescale 1ns/1ps
module tb_weight_mem_sequencer;
   import weight_pkg::*;

   localparam int DW = 64;
   localparam int IW = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic          a_load_start = 0, a_rd_start = 0, a_clear = 0, a_in_valid = 0, a_rd_ready = 0;
   logic [DW-1:0] a_in_data = '0;
   logic          a_in_ready, a_mem_write, a_rd_valid, a_rd_last, a_load_done, a_rd_done, a_loaded, a_busy;
   logic [IW-1:0] a_wi, a_wo, a_wy, a_wx, a_ri, a_ro, a_ry, a_rx;
   logic [DW-1:0] a_wdata;

   logic          b_load_start = 0, b_rd_start = 0, b_clear = 0, b_in_valid = 0, b_rd_ready = 0;
   logic [DW-1:0] b_in_data = '0;
   logic          b_in_ready, b_mem_write, b_rd_valid, b_rd_last, b_load_done, b_rd_done, b_loaded, b_busy;
   logic [IW-1:0] b_wi, b_wo, b_wy, b_wx, b_ri, b_ro, b_ry, b_rx;
   logic [DW-1:0] b_wdata;

   weight_mem_sequencer #(.NUM_INPUTS(1), .NUM_OUTPUTS(1), .DIM(3), .DATA_SIZE(DW), .IDX_W(IW)) u_a (
      .clk(clk), .rst_n(rst_n), .load_start(a_load_start), .rd_start(a_rd_start), .clear(a_clear),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .mem_write(a_mem_write),
      .mem_index_in(a_wi), .mem_index_out(a_wo), .mem_index_k_y(a_wy), .mem_index_k_x(a_wx),
      .mem_wdata(a_wdata), .mem_rd_index_in(a_ri), .mem_rd_index_out(a_ro), .mem_rd_index_y(a_ry),
      .mem_rd_index_x(a_rx), .rd_valid(a_rd_valid), .rd_ready(a_rd_ready), .rd_last(a_rd_last),
      .load_done(a_load_done), .rd_done(a_rd_done), .loaded(a_loaded), .busy(a_busy)
   );

   weight_mem_sequencer #(.NUM_INPUTS(2), .NUM_OUTPUTS(2), .DIM(2), .DATA_SIZE(DW), .IDX_W(IW)) u_b (
      .clk(clk), .rst_n(rst_n), .load_start(b_load_start), .rd_start(b_rd_start), .clear(b_clear),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .mem_write(b_mem_write),
      .mem_index_in(b_wi), .mem_index_out(b_wo), .mem_index_k_y(b_wy), .mem_index_k_x(b_wx),
      .mem_wdata(b_wdata), .mem_rd_index_in(b_ri), .mem_rd_index_out(b_ro), .mem_rd_index_y(b_ry),
      .mem_rd_index_x(b_rx), .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_last(b_rd_last),
      .load_done(b_load_done), .rd_done(b_rd_done), .loaded(b_loaded), .busy(b_busy)
   );

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({a_in_ready, a_mem_write, a_rd_valid, a_rd_last, a_load_done, a_rd_done, a_loaded, a_busy} !== 8'b0) begin
         errors++; $display("FAIL reset_ctrl_a got %b want 00000000",
            {a_in_ready, a_mem_write, a_rd_valid, a_rd_last, a_load_done, a_rd_done, a_loaded, a_busy});
      end
      checks++;
      if ({a_wi, a_wo, a_wy, a_wx, a_ri, a_ro, a_ry, a_rx} !== '0 || a_wdata !== '0) begin
         errors++; $display("FAIL reset_idx_a got %h data %h want 0", {a_wi, a_wo, a_wy, a_wx, a_ri, a_ro, a_ry, a_rx}, a_wdata);
      end
      checks++;
      if ({b_in_ready, b_mem_write, b_rd_valid, b_rd_last, b_load_done, b_rd_done, b_loaded, b_busy} !== 8'b0 ||
          {b_wi, b_wo, b_wy, b_wx, b_ri, b_ro, b_ry, b_rx} !== '0) begin
         errors++; $display("FAIL reset_b got ctrl %b idx %h want 0",
            {b_in_ready, b_mem_write, b_rd_valid, b_rd_last, b_load_done, b_rd_done, b_loaded, b_busy},
            {b_wi, b_wo, b_wy, b_wx, b_ri, b_ro, b_ry, b_rx});
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Loads 1.0..9.0 into instance A, back-to-back or with in_valid toggling.
   task automatic test_load_a(input bit toggle);
      int   sent, writes, dones, ncyc;
      logic prev_acc;
      sent = 0; writes = 0; dones = 0; prev_acc = 1'b0;
      ncyc = toggle ? 26 : 16;
      @(posedge clk); #1 a_load_start = 1'b1;
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk); #1;
         a_load_start = 1'b0;
         a_in_valid = (sent < 9) && (!toggle || (c % 2 == 0));
         a_in_data = $realtobits(real'(sent + 1));
         @(negedge clk);
         checks++;
         if (a_mem_write !== prev_acc) begin
            errors++; $display("FAIL load_a_wr_timing cyc %0d got %b want %b", c, a_mem_write, prev_acc);
         end
         if (a_mem_write === 1'b1) begin
            checks++;
            if ({a_wi, a_wo, a_wy, a_wx} !== {IW'(0), IW'(0), IW'(writes / 3), IW'(writes % 3)} ||
                a_wdata !== $realtobits(real'(writes + 1))) begin
               errors++; $display("FAIL load_a_write %0d got idx %h data %h want ky %0d kx %0d data %h",
                  writes, {a_wi, a_wo, a_wy, a_wx}, a_wdata, writes / 3, writes % 3, $realtobits(real'(writes + 1)));
            end
            writes++;
            checks++;
            if (a_load_done !== (writes == 9)) begin
               errors++; $display("FAIL load_a_done at write %0d got %b want %b", writes, a_load_done, writes == 9);
            end
         end
         if (a_load_done === 1'b1) dones++;
         if (writes < 9) begin
            checks++;
            if (a_loaded !== 1'b0) begin
               errors++; $display("FAIL load_a_loaded_early cyc %0d got %b want 0", c, a_loaded);
            end
         end
         prev_acc = a_in_valid & a_in_ready;
         if (prev_acc) sent++;
      end
      a_in_valid = 1'b0;
      checks++;
      if (writes != total_words(1, 1, 3) || dones != 1) begin
         errors++; $display("FAIL load_a_counts got writes %0d dones %0d want 9 1", writes, dones);
      end
      checks++;
      if (a_loaded !== 1'b1 || a_in_ready !== 1'b0 || a_busy !== 1'b0) begin
         errors++; $display("FAIL load_a_end got loaded %b ready %b busy %b want 1 0 0", a_loaded, a_in_ready, a_busy);
      end
   endtask

   task automatic load_b();
      int   sent, writes;
      sent = 0; writes = 0;
      @(posedge clk); #1 b_load_start = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         b_load_start = 1'b0;
         b_in_valid = (sent < 16);
         b_in_data = DW'(sent + 100);
         @(negedge clk);
         if (b_mem_write === 1'b1) begin
            checks++;
            if ({b_wi, b_wo, b_wy, b_wx} !== {IW'(writes / 8), IW'((writes / 4) % 2), IW'((writes / 2) % 2), IW'(writes % 2)} ||
                b_wdata !== DW'(writes + 100)) begin
               errors++; $display("FAIL load_b_write %0d got idx %h data %h want n %0d", writes,
                  {b_wi, b_wo, b_wy, b_wx}, b_wdata, writes);
            end
            writes++;
         end
         if (b_in_valid && b_in_ready) sent++;
      end
      b_in_valid = 1'b0;
      checks++;
      if (writes != total_words(2, 2, 2) || b_loaded !== 1'b1) begin
         errors++; $display("FAIL load_b_end got writes %0d loaded %b want 16 1", writes, b_loaded);
      end
   endtask

   task automatic test_read_sweep(input bit stall);
      int   n, dones, stalls;
      logic prev_final;
      n = 0; dones = 0; stalls = 0; prev_final = 1'b0;
      @(posedge clk); #1 b_rd_start = 1'b1;
      for (int c = 0; c < 24; c++) begin
         @(posedge clk); #1;
         b_rd_start = 1'b0;
         if (stall && n == 5 && stalls < 3) begin
            b_rd_ready = 1'b0; stalls++;
         end else begin
            b_rd_ready = 1'b1;
         end
         @(negedge clk);
         checks++;
         if (b_rd_valid !== (n < 16)) begin
            errors++; $display("FAIL read_valid cyc %0d got %b want %b", c, b_rd_valid, n < 16);
         end
         if (n < 16) begin
            checks++;
            if ({b_ri, b_ro, b_ry, b_rx} !== {IW'(n / 8), IW'((n / 4) % 2), IW'((n / 2) % 2), IW'(n % 2)} ||
                b_rd_last !== (n == 15)) begin
               errors++; $display("FAIL read_word %0d got idx %h last %b want %0d%0d%0d%0d last %b", n,
                  {b_ri, b_ro, b_ry, b_rx}, b_rd_last, n / 8, (n / 4) % 2, (n / 2) % 2, n % 2, n == 15);
            end
         end
         checks++;
         if (b_rd_done !== prev_final) begin
            errors++; $display("FAIL read_done cyc %0d got %b want %b", c, b_rd_done, prev_final);
         end
         if (b_rd_done === 1'b1) dones++;
         prev_final = (b_rd_valid === 1'b1) && b_rd_ready && (n == 15);
         if (b_rd_valid === 1'b1 && b_rd_ready) n++;
      end
      b_rd_ready = 1'b0;
      checks++;
      if (n != 16 || dones != 1 || b_busy !== 1'b0 || b_loaded !== 1'b1 || (stall && stalls != 3)) begin
         errors++; $display("FAIL read_end got hs %0d dones %0d busy %b loaded %b stalls %0d want 16 1 0 1",
            n, dones, b_busy, b_loaded, stalls);
      end
   endtask

   task automatic test_priority();
      @(posedge clk); #1 b_load_start = 1'b1; b_rd_start = 1'b1;
      @(posedge clk); #1 b_load_start = 1'b0; b_rd_start = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if (b_busy !== 1'b1 || b_loaded !== 1'b0 || b_in_ready !== 1'b1 || b_rd_valid !== 1'b0) begin
            errors++; $display("FAIL priority cyc %0d got busy %b loaded %b ready %b rd_valid %b want 1 0 1 0",
               c, b_busy, b_loaded, b_in_ready, b_rd_valid);
         end
      end
   endtask

   task automatic test_clear();
      @(posedge clk); #1 b_clear = 1'b1; b_in_valid = 1'b1;
      @(posedge clk); #1 b_clear = 1'b0;
      @(negedge clk);
      checks++;
      if (b_busy !== 1'b0 || b_in_ready !== 1'b0 || b_loaded !== 1'b0 || b_mem_write !== 1'b0) begin
         errors++; $display("FAIL clear got busy %b ready %b loaded %b wr %b want 0 0 0 0",
            b_busy, b_in_ready, b_loaded, b_mem_write);
      end
      @(posedge clk); #1 b_rd_start = 1'b1;
      @(posedge clk); #1 b_rd_start = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if (b_rd_valid !== 1'b0 || b_busy !== 1'b0 || b_mem_write !== 1'b0) begin
            errors++; $display("FAIL idle_ignore cyc %0d got rd_valid %b busy %b wr %b want 0 0 0",
               c, b_rd_valid, b_busy, b_mem_write);
         end
      end
      b_in_valid = 1'b0;
   endtask

   task automatic test_reset_mid_load();
      @(posedge clk); #1 a_load_start = 1'b1;
      @(posedge clk); #1 a_load_start = 1'b0; a_in_valid = 1'b1; a_in_data = 64'h1;
      repeat (4) @(posedge clk);
      #1 a_in_valid = 1'b0;
      checks++;
      if (a_mem_write !== 1'b1 || a_busy !== 1'b1 || a_wx !== IW'(0) || a_wy !== IW'(1)) begin
         errors++; $display("FAIL mid_load_state got wr %b busy %b ky %0d kx %0d want 1 1 1 0",
            a_mem_write, a_busy, a_wy, a_wx);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({a_in_ready, a_mem_write, a_loaded, a_busy, a_load_done} !== 5'b0 || {a_wi, a_wo, a_wy, a_wx} !== '0 ||
          a_wdata !== '0) begin
         errors++; $display("FAIL async_reset got ctrl %b idx %h data %h want 0",
            {a_in_ready, a_mem_write, a_loaded, a_busy, a_load_done}, {a_wi, a_wo, a_wy, a_wx}, a_wdata);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1 a_rd_start = 1'b1;
      @(posedge clk); #1 a_rd_start = 1'b0;
      @(negedge clk);
      checks++;
      if (a_rd_valid !== 1'b0 || a_loaded !== 1'b0 || a_busy !== 1'b0) begin
         errors++; $display("FAIL rd_after_reset got rd_valid %b loaded %b busy %b want 0 0 0", a_rd_valid, a_loaded, a_busy);
      end
      test_load_a(1'b0);
      @(posedge clk); #1 a_rd_start = 1'b1; a_rd_ready = 1'b0;
      @(posedge clk); #1 a_rd_start = 1'b0;
      @(negedge clk);
      checks++;
      if (a_rd_valid !== 1'b1 || a_rd_last !== 1'b0 || {a_ri, a_ro, a_ry, a_rx} !== '0) begin
         errors++; $display("FAIL rd_after_reload got rd_valid %b last %b idx %h want 1 0 0",
            a_rd_valid, a_rd_last, {a_ri, a_ro, a_ry, a_rx});
      end
   endtask

   initial begin
      test_reset();
      test_load_a(1'b0);
      test_load_a(1'b1);
      load_b();
      test_read_sweep(1'b0);
      test_read_sweep(1'b0);
      test_read_sweep(1'b1);
      test_priority();
      test_clear();
      test_reset_mid_load();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
